// File: rtl/correlator_pkg.sv
// rtl/correlator_pkg.sv - shared types and width helper for the pattern correlator
package correlator_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int score_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/bit_score.sv
// rtl/bit_score.sv - combinational count of word bits agreeing with the reference pattern
module bit_score
  import correlator_pkg::*;
#(
  parameter int                WORD_W  = 3,
  parameter logic [WORD_W-1:0] PATTERN = 3'b101,
  localparam int               SW      = score_w(WORD_W)
) (
  input  logic [WORD_W-1:0] word,
  output logic [SW-1:0]     score
);

  always_comb begin
    score = '0;
    for (int i = 0; i < WORD_W; i++) begin
      score = score + SW'(word[i] == PATTERN[i]);
    end
  end

endmodule

// File: rtl/pattern_correlator.sv
// rtl/pattern_correlator.sv - per-word pattern score, hit counter and hysteretic lock detector
module pattern_correlator
  import correlator_pkg::*;
#(
  parameter int                WORD_W    = 3,
  parameter logic [WORD_W-1:0] PATTERN   = 3'b101,
  parameter int                THRESHOLD = 3,
  parameter int                LOCK_N    = 2,
  parameter int                MISS_N    = 2,
  parameter int                CNT_W     = 8,
  localparam int               SW        = score_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              clear_count,
  output logic [SW-1:0]     score,
  output logic              score_valid,
  output logic              hit,
  output logic              locked,
  output logic [CNT_W-1:0]  hit_count,
  output logic              sat
);

  localparam int RUN_MAX = (LOCK_N > MISS_N) ? LOCK_N : MISS_N;
  localparam int RW      = $clog2(RUN_MAX + 1);

  logic          valid_d;
  logic          load;
  logic [SW-1:0] score_c;
  logic          hit_c;
  logic [RW-1:0] run_q, run_n, run_inc;
  state_t        state, state_n;

  bit_score #(.WORD_W(WORD_W), .PATTERN(PATTERN)) u_bit_score (
    .word  (word_in),
    .score (score_c)
  );

  assign load    = word_valid & ~valid_d;
  assign hit_c   = (score_c >= SW'(THRESHOLD));
  assign run_inc = run_q + RW'(1);
  assign locked  = (state == LOCKED);
  assign sat     = &hit_count;

  always_comb begin
    state_n = state;
    run_n   = run_q;
    if (load) begin
      case (state)
        SEARCH: begin
          if (!hit_c) begin
            run_n = '0;
          end else if (run_inc == RW'(LOCK_N)) begin
            state_n = LOCKED;
            run_n   = '0;
          end else begin
            run_n = run_inc;
          end
        end
        LOCKED: begin
          if (hit_c) begin
            run_n = '0;
          end else if (run_inc == RW'(MISS_N)) begin
            state_n = SEARCH;
            run_n   = '0;
          end else begin
            run_n = run_inc;
          end
        end
        default: begin
          state_n = SEARCH;
          run_n   = '0;
        end
      endcase
    end
  end

  // valid_d resets high so a strobe already asserted at reset release is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d     <= 1'b1;
      score       <= '0;
      score_valid <= 1'b0;
      hit         <= 1'b0;
      state       <= SEARCH;
      run_q       <= '0;
      hit_count   <= '0;
    end else begin
      valid_d     <= word_valid;
      score_valid <= load;
      state       <= state_n;
      run_q       <= run_n;
      if (load) begin
        score <= score_c;
        hit   <= hit_c;
      end
      if (clear_count) begin
        hit_count <= '0;
      end else if (load && hit_c && !sat) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_correlator.sv
// tb/tb_pattern_correlator.sv - directed self-checking bench for pattern_correlator
module tb_pattern_correlator;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] word_in;
  logic       word_valid;
  logic       clear_count;

  logic [1:0] score,  score2;
  logic       score_valid, score_valid2;
  logic       hit,    hit2;
  logic       locked, locked2;
  logic [7:0] hit_count;
  logic [1:0] hit_count2;
  logic       sat,    sat2;

  int checks   = 0;
  int failures = 0;
  int pulses;
  logic sv_seen;

  always #5 clk = ~clk;

  pattern_correlator dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .clear_count (clear_count),
    .score       (score),
    .score_valid (score_valid),
    .hit         (hit),
    .locked      (locked),
    .hit_count   (hit_count),
    .sat         (sat)
  );

  pattern_correlator #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .clear_count (clear_count),
    .score       (score2),
    .score_valid (score_valid2),
    .hit         (hit2),
    .locked      (locked2),
    .hit_count   (hit_count2),
    .sat         (sat2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one-cycle strobe followed by one idle cycle; sv_seen captures the pulse cycle
  task automatic send(input logic [2:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    sv_seen    = score_valid;
    word_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    word_valid  = 1'b1;
    word_in     = 3'b101;
    clear_count = 1'b0;
    repeat (3) tick();
    chk("rst_score",     score,       0);
    chk("rst_hit",       hit,         0);
    chk("rst_sv",        score_valid, 0);
    chk("rst_locked",    locked,      0);
    chk("rst_hit_count", hit_count,   0);
    chk("rst_sat",       sat,         0);

    rst = 1'b0;
    tick();
    chk("held_after_rst_sv0", score_valid, 0);
    tick();
    chk("held_after_rst_sv1", score_valid, 0);
    chk("held_after_rst_cnt", hit_count,   0);
    word_valid = 1'b0;
    tick();
    chk("fall_sv", score_valid, 0);

    word_in    = 3'b101;
    word_valid = 1'b1;
    tick();
    chk("single_score",  score,       3);
    chk("single_hit",    hit,         1);
    chk("single_sv",     score_valid, 1);
    chk("single_cnt",    hit_count,   1);
    chk("single_locked", locked,      0);
    word_valid = 1'b0;
    tick();
    chk("single_sv_drop",   score_valid, 0);
    chk("single_score_hold", score,      3);

    send(3'b001);
    chk("w001_sv",    sv_seen,   1);
    chk("w001_score", score,     2);
    chk("w001_hit",   hit,       0);
    chk("w001_cnt",   hit_count, 1);

    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("clear_cnt", hit_count, 0);
    word_in    = 3'b101;
    word_valid = 1'b1;
    pulses     = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (score_valid) pulses++;
    end
    word_valid = 1'b0;
    tick();
    if (score_valid) pulses++;
    chk("held_pulses", pulses,    1);
    chk("held_cnt",    hit_count, 1);

    do_reset();
    send(3'b101);
    chk("lock_w1", locked, 0);
    send(3'b101);
    chk("lock_w2", locked, 1);
    send(3'b010);
    chk("lock_w3_score", score,  0);
    chk("lock_w3",       locked, 1);
    send(3'b101);
    chk("lock_w4", locked, 1);
    send(3'b111);
    chk("lock_w5_score", score,  2);
    chk("lock_w5",       locked, 1);
    send(3'b000);
    chk("lock_w6_score", score,     1);
    chk("lock_w6",       locked,    0);
    chk("lock_cnt",      hit_count, 3);

    do_reset();
    for (int i = 0; i < 4; i++) send(3'b101);
    chk("sat4_cnt2", hit_count2, 3);
    chk("sat4_sat2", sat2,       1);
    chk("sat4_cnt",  hit_count,  4);
    chk("sat4_sat",  sat,        0);
    send(3'b101);
    chk("sat5_cnt2", hit_count2, 3);
    chk("sat5_cnt",  hit_count,  5);
    word_in     = 3'b101;
    word_valid  = 1'b1;
    clear_count = 1'b1;
    tick();
    chk("clr_hit_sv",   score_valid2, 1);
    chk("clr_hit_cnt2", hit_count2,   0);
    chk("clr_hit_sat2", sat2,         0);
    chk("clr_hit_cnt",  hit_count,    0);
    chk("clr_hit_lock", locked,       1);
    clear_count = 1'b0;
    word_valid  = 1'b0;
    tick();

    do_reset();
    for (int i = 0; i < 5; i++) send(3'b101);
    chk("mid_pre_locked", locked,    1);
    chk("mid_pre_cnt",    hit_count, 5);
    word_in    = 3'b101;
    word_valid = 1'b1;
    rst        = 1'b1;
    tick();
    chk("mid_sv",     score_valid, 0);
    chk("mid_locked", locked,      0);
    chk("mid_cnt",    hit_count,   0);
    chk("mid_score",  score,       0);
    rst        = 1'b0;
    word_valid = 1'b0;
    tick();
    chk("mid_after_sv", score_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
